// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared constants, AXI encodings and FSM states for the icache refill engine
//
// Contents:
//   WORD                 - data word width in bits
//   DEFAULT_LINE_WORDS   - cache-line word count shared with the ICache
//   BURST_INCR/WRAP      - AXI4 arburst encodings
//   RESP_OKAY            - AXI4 rresp value for a good beat
//   SIZE_WORD            - AXI4 arsize for 32-bit beats
//   refill_state_e       - refill FSM state encoding
package icache_refill_pkg;

    localparam int WORD               = 32;
    localparam int DEFAULT_LINE_WORDS = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_line_buf.sv
// rtl/icache_refill_line_buf.sv - registered cache-line buffer with word-indexed write port
//
// Module refill_line_buf
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low clear of every word
//   wr_en    in   write wr_data into word wr_idx this cycle
//   wr_idx   in   word index within the line
//   wr_data  in   word to store
//   line     out  whole line, word i at bits [32i+31:32i]
module refill_line_buf
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx,
    input  logic [WORD-1:0]               wr_data,
    output logic [WORD*LINE_WORDS-1:0]    line
);

    logic [WORD-1:0] words [LINE_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
        assign line[g*WORD +: WORD] = words[g];
    end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache line-refill engine: one AXI4 read burst per miss, assembled into a line
//
// Build option: define ICACHE_REFILL_WRAP_EN for critical-word-first WRAP bursts;
// undefined issues a line-aligned INCR burst.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   memory_valid/load_addr miss request from the ICache, held until memory_ready
//   memory_ready           one-cycle pulse, line_data valid
//   line_data              assembled line, word i at bits [32i+31:32i]
//   refill_err             with memory_ready: bus error or beat-count/rlast mismatch
//   ar*                    AXI4 read-address channel
//   r*                     AXI4 read-data channel (rid unused: one outstanding burst)
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int         LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter logic [3:0] ARID_VAL   = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memory_valid,
    input  logic [31:0]                load_addr,
    output logic                       memory_ready,
    output logic [WORD*LINE_WORDS-1:0] line_data,
    output logic                       refill_err,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [3:0]                 arid,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast
);

    localparam int               IDX_W     = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    refill_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] start_q;
    logic             err_q;
    logic [31:0]      araddr_q;

    logic [31:0]      req_addr;
    logic [IDX_W-1:0] req_start;
    logic [1:0]       burst;
    logic             is_last;
    logic             beat_err;
    logic             beat_fire;

`ifdef ICACHE_REFILL_WRAP_EN
    // Critical word first: the bus starts at the missed word and wraps at the line boundary.
    assign req_addr  = {load_addr[31:2], 2'b00};
    assign req_start = load_addr[IDX_W+1:2];
    assign burst     = BURST_WRAP;
`else
    assign req_addr  = load_addr & ~32'(LINE_WORDS*4 - 1);
    assign req_start = '0;
    assign burst     = BURST_INCR;
`endif

    // The beat counter decides completion; rlast is only cross-checked against it.
    assign is_last   = (cnt_q == LAST_BEAT);
    assign beat_fire = (state_q == ST_R) && rvalid;
    assign beat_err  = (rresp != RESP_OKAY) || (rlast != is_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            start_q  <= '0;
            err_q    <= 1'b0;
            araddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && memory_valid) begin
                araddr_q <= req_addr;
                start_q  <= req_start;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else if (beat_fire) begin
                cnt_q <= cnt_q + IDX_W'(1);
                err_q <= err_q | beat_err;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        memory_ready = 1'b0;
        refill_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memory_valid) begin
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid && is_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                memory_ready = 1'b1;
                refill_err   = err_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign araddr  = araddr_q;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_WORD;
    assign arburst = burst;
    assign arid    = ARID_VAL;

    refill_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat_fire),
        .wr_idx  (start_q + cnt_q),
        .wr_data (rdata),
        .line    (line_data)
    );

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - randomized scoreboard bench for icache_refill
module tb_icache_refill;
    import icache_refill_pkg::*;

    localparam int         LW   = DEFAULT_LINE_WORDS;
    localparam logic [3:0] ARID = 4'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              memory_valid = 1'b0;
    logic [31:0]       load_addr = '0;
    logic              memory_ready;
    logic [WORD*LW-1:0] line_data;
    logic              refill_err;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arid;
    logic              rvalid = 1'b0;
    logic              rready;
    logic [31:0]       rdata = '0;
    logic [1:0]        rresp = '0;
    logic              rlast = 1'b0;

    icache_refill #(
        .LINE_WORDS (LW),
        .ARID_VAL   (ARID)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memory_valid (memory_valid),
        .load_addr    (load_addr),
        .memory_ready (memory_ready),
        .line_data    (line_data),
        .refill_err   (refill_err),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arid         (arid),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WORD*LW-1:0] line;
        logic               err;
        int                 rdy_cyc;
    } exp_t;

    exp_t sb[$];

    logic [31:0] beat_data [LW];
    int          beat_gap  [LW];
    logic [1:0]  beat_resp [LW];
    bit          beat_flip [LW];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_memory_ready", memory_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_refill_err", refill_err, 0);
        chk("rst_line_data", line_data, 0);
        chk("rst_araddr", araddr, 0);
    endtask

    // Monitor: every memory_ready pulse is matched against the oldest expected refill.
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (memory_ready) begin
            chk("ready_not_consecutive", prev_rdy, 0);
            if (sb.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("line_data", line_data, e.line);
                chk("refill_err", refill_err, e.err);
                chk("ready_cycle", cyc, e.rdy_cyc);
            end
        end
        prev_rdy = memory_ready;
    end

    task automatic plain_beats(input logic [31:0] base);
        for (int b = 0; b < LW; b++) begin
            beat_data[b] = base + b;
            beat_gap[b]  = 0;
            beat_resp[b] = RESP_OKAY;
            beat_flip[b] = 1'b0;
        end
    endtask

    task automatic random_beats();
        for (int b = 0; b < LW; b++) begin
            beat_data[b] = $urandom;
            beat_gap[b]  = $urandom_range(0, 2);
            beat_resp[b] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            beat_flip[b] = ($urandom_range(0, 9) == 0);
        end
    endtask

    // One refill, acting as both requester and AXI slave. abort_after >= 0 pulls
    // reset once that many beats have been delivered.
    task automatic do_refill(input logic [31:0] addr, input int ar_delay,
                             input int abort_after, input bit drop_valid);
        exp_t        e;
        int          start;
        int          gaps;
        int          n;
        logic [31:0] exp_addr;
        logic [1:0]  exp_burst;

        @(negedge clk);
`ifdef ICACHE_REFILL_WRAP_EN
        start     = int'((addr >> 2) % LW);
        exp_addr  = addr & ~32'd3;
        exp_burst = 2'b10;
`else
        start     = 0;
        exp_addr  = addr - (addr % (LW * 4));
        exp_burst = 2'b01;
`endif
        e.line = '0;
        e.err  = 1'b0;
        gaps   = 0;
        for (int b = 0; b < LW; b++) begin
            e.line[((start + b) % LW) * WORD +: WORD] = beat_data[b];
            if (beat_resp[b] != RESP_OKAY || beat_flip[b]) e.err = 1'b1;
            if (b > 0) gaps += beat_gap[b];
        end
        e.rdy_cyc = cyc + LW + 2 + ar_delay + gaps;
        if (abort_after < 0) sb.push_back(e);

        memory_valid = 1'b1;
        load_addr    = addr;
        @(negedge clk);
        chk("arvalid_latency", arvalid, 1);
        n = 0;
        while (!arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!arvalid) begin
            chk("arvalid_timeout", 0, 1);
            memory_valid = 1'b0;
            sb.delete();
            return;
        end
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, LW - 1);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, exp_burst);
        chk("arid", arid, ARID);
        repeat (ar_delay) @(negedge clk);
        chk("arvalid_held", arvalid, 1);
        chk("araddr_held", araddr, exp_addr);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        if (drop_valid) begin
            memory_valid = 1'b0;
            load_addr    = $urandom;
        end

        for (int b = 0; b < LW; b++) begin
            if (b > 0) begin
                for (int g = 0; g < beat_gap[b]; g++) begin
                    rvalid = 1'b0;
                    @(negedge clk);
                end
            end
            if (b == abort_after) begin
                rvalid       = 1'b0;
                memory_valid = 1'b0;
                rst          = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            chk("rready", rready, 1);
            rvalid = 1'b1;
            rdata  = beat_data[b];
            rresp  = beat_resp[b];
            rlast  = (b == LW - 1) ^ beat_flip[b];
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = RESP_OKAY;

        n = 0;
        while (!memory_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!memory_ready) begin
            chk("ready_timeout", 0, 1);
            sb.delete();
        end
        memory_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        plain_beats(32'hA0);
        do_refill(32'h1C000014, 0, -1, 1'b0);

        random_beats();
        for (int b = 0; b < LW; b++) begin
            beat_gap[b] = 0; beat_resp[b] = RESP_OKAY; beat_flip[b] = 1'b0;
        end
        do_refill(32'h00000008, 0, -1, 1'b0);

        plain_beats(32'h5500_0000);
        for (int b = 0; b < LW; b++) beat_gap[b] = 1;
        do_refill(32'h8000_0040, 3, -1, 1'b0);

        plain_beats(32'h1111_0000);
        beat_resp[1] = 2'b10;
        do_refill(32'h0000_1234, 0, -1, 1'b0);

        plain_beats(32'h2222_0000);
        beat_flip[2] = 1'b1;
        do_refill(32'h0000_5678, 1, -1, 1'b1);

        plain_beats(32'h3333_0000);
        do_refill(32'h4000_0010, 0, 2, 1'b0);
        plain_beats(32'h4444_0000);
        do_refill(32'h4000_0020, 0, -1, 1'b0);

        // Consecutive calls re-raise memory_valid the cycle after memory_ready.
        plain_beats(32'h6666_0000);
        do_refill(32'h0000_0100, 0, -1, 1'b0);
        plain_beats(32'h7777_0000);
        do_refill(32'h0000_0204, 0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            random_beats();
            do_refill($urandom, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
